// File: rtl/fixed_point_pkg.sv
// Shared definitions for the fixed-point arithmetic blocks.
//   state_t         : sequencer states of the multi-cycle adder/subtractor
//   max_pos/min_neg : two's-complement saturation limits for a given width,
//                     returned in a MAX_W-bit container (callers truncate)
//   overflow_detect : signed overflow of a + b from the three sign bits
package fixed_point_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] max_pos(input int width);
    max_pos = (MAX_W'(1) << (width - 1)) - MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] min_neg(input int width);
    min_neg = MAX_W'(1) << (width - 1);
  endfunction

  // Overflow only when both addends share a sign and the sum's sign differs.
  function automatic logic overflow_detect(input logic a_msb, input logic b_msb,
                                           input logic s_msb);
    overflow_detect = (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/fixed_point_chunk_adder.sv
// Combinational W-bit ripple slice with carry in/out.
//   a, b : slice operands
//   cin  : carry into the slice
//   sum  : slice sum
//   cout : carry out of the slice
module fixed_point_chunk_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/fixed_point_addsub_mc.sv
// Multi-cycle signed fixed-point adder/subtractor, CHUNK bits per clock, LSB first.
// Ports:
//   i_clk, i_rst          : clock (rising edge), synchronous active-high reset
//   i_start               : request, sampled only when not busy (IDLE or DONE)
//   i_sub                 : 0 = A+B, 1 = A-B, latched with start
//   i_operandA/i_operandB : signed operands, latched with start
//   o_busy                : computation in progress (RUN)
//   o_valid               : o_data holds a completed result
//   o_done                : one-cycle completion pulse (DONE)
//   o_data, o_overflow    : result and its signed-overflow flag
//   o_dbg_state           : current sequencer state, for observation only
// Handshake: a start is taken on any rising edge where i_start=1 and the block
// is in IDLE or DONE; starts during RUN are dropped. o_done is high for exactly
// the one cycle after the edge that finishes the last chunk, and o_data/o_overflow
// hold until overwritten by a later result or cleared by reset.
module fixed_point_addsub_mc
  import fixed_point_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 8,
  parameter int CHUNK    = 4,
  parameter int SATURATE = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_operandA,
  input  logic [WIDTH-1:0] i_operandB,
  output logic             o_busy,
  output logic             o_valid,
  output logic             o_done,
  output logic [WIDTH-1:0] o_data,
  output logic             o_overflow,
  output logic [1:0]       o_dbg_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0]    LAST    = CW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(max_pos(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(min_neg(WIDTH));

  if (WIDTH < 2) begin : g_bad_width
    $error("fixed_point_addsub_mc: WIDTH must be at least 2");
  end
  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("fixed_point_addsub_mc: WIDTH must be a multiple of CHUNK");
  end
  if (FRAC < 0 || FRAC > WIDTH) begin : g_bad_frac
    $error("fixed_point_addsub_mc: FRAC must lie within 0..WIDTH");
  end

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg, sum_next;
  logic             carry;
  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;
  logic             accept, last, ovf_now;
  logic [WIDTH-1:0] result_now;
  int               base;

  assign base = int'(cnt) * CHUNK;

  fixed_point_chunk_adder #(.W(CHUNK)) u_chunk (
    .a    (a_reg[base +: CHUNK]),
    .b    (b_reg[base +: CHUNK]),
    .cin  (carry),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

  // Full sum as it stands once the current slice is merged in; on the last
  // chunk this is the complete result, so overflow/saturation read it directly.
  always_comb begin
    sum_next = sum_reg;
    sum_next[base +: CHUNK] = chunk_sum;
  end

  assign accept     = i_start && (state != RUN);
  assign last       = (cnt == LAST);
  assign ovf_now    = overflow_detect(a_reg[WIDTH-1], b_reg[WIDTH-1], sum_next[WIDTH-1]);
  assign result_now = (ovf_now && (SATURATE != 0))
                      ? (a_reg[WIDTH-1] ? SAT_MIN : SAT_MAX) : sum_next;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_start) state_next = RUN;
      RUN:     if (last)    state_next = DONE;
      DONE:    state_next = i_start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      sum_reg    <= '0;
      carry      <= 1'b0;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_overflow <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        // Subtraction as A + ~B + 1: the +1 enters as the initial carry.
        a_reg   <= i_operandA;
        b_reg   <= i_sub ? ~i_operandB : i_operandB;
        carry   <= i_sub;
        cnt     <= '0;
        sum_reg <= '0;
        o_valid <= 1'b0;
      end else if (state == RUN) begin
        sum_reg <= sum_next;
        carry   <= chunk_cout;
        cnt     <= cnt + CW'(1);
        if (last) begin
          o_data     <= result_now;
          o_overflow <= ovf_now;
          o_valid    <= 1'b1;
        end
      end
    end
  end

  assign o_busy      = (state == RUN);
  assign o_done      = (state == DONE);
  assign o_dbg_state = state;

`ifdef FORMAL
  logic             f_past_valid = 1'b0;
  logic [WIDTH-1:0] f_ref;
  always_ff @(posedge i_clk) begin
    f_past_valid <= 1'b1;
    if (accept) f_ref <= i_sub ? (i_operandA - i_operandB) : (i_operandA + i_operandB);
  end
  always_comb begin
    if (f_past_valid) begin
      assert (!(o_busy && o_done));
      if (o_done && !o_overflow) assert (o_data == f_ref);
      cover (o_done && o_overflow);
      cover (o_done && !o_overflow);
    end
  end
`endif

endmodule

// File: tb/tb_fixed_point_addsub_mc.sv
// Self-checking bench for fixed_point_addsub_mc. Three instances share the
// operand buses: defaults (saturating), SATURATE=0, and WIDTH=CHUNK=8.
module tb_fixed_point_addsub_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a_in, b_in;
  logic        sub_in;
  logic        st_m, st_w, st_c;

  logic        m_busy, m_valid, m_done, m_ovf;
  logic [15:0] m_data;
  logic [1:0]  m_state;
  logic        w_busy, w_valid, w_done, w_ovf;
  logic [15:0] w_data;
  logic [1:0]  w_state;
  logic        c_busy, c_valid, c_done, c_ovf;
  logic [7:0]  c_data;
  logic [1:0]  c_state;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fixed_point_addsub_mc u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(st_m), .i_sub(sub_in),
    .i_operandA(a_in), .i_operandB(b_in),
    .o_busy(m_busy), .o_valid(m_valid), .o_done(m_done),
    .o_data(m_data), .o_overflow(m_ovf), .o_dbg_state(m_state)
  );

  fixed_point_addsub_mc #(.SATURATE(0)) u_wrap (
    .i_clk(clk), .i_rst(rst), .i_start(st_w), .i_sub(sub_in),
    .i_operandA(a_in), .i_operandB(b_in),
    .o_busy(w_busy), .o_valid(w_valid), .o_done(w_done),
    .o_data(w_data), .o_overflow(w_ovf), .o_dbg_state(w_state)
  );

  fixed_point_addsub_mc #(.WIDTH(8), .FRAC(4), .CHUNK(8)) u_c8 (
    .i_clk(clk), .i_rst(rst), .i_start(st_c), .i_sub(sub_in),
    .i_operandA(a_in[7:0]), .i_operandB(b_in[7:0]),
    .o_busy(c_busy), .o_valid(c_valid), .o_done(c_done),
    .o_data(c_data), .o_overflow(c_ovf), .o_dbg_state(c_state)
  );

  // Output view of the instance currently under test
  int          sel = 0;
  logic        s_busy, s_valid, s_done, s_ovf;
  logic [15:0] s_data;
  always_comb begin
    s_busy = m_busy; s_valid = m_valid; s_done = m_done; s_ovf = m_ovf; s_data = m_data;
    if (sel == 1) begin
      s_busy = w_busy; s_valid = w_valid; s_done = w_done; s_ovf = w_ovf; s_data = w_data;
    end else if (sel == 2) begin
      s_busy = c_busy; s_valid = c_valid; s_done = c_done; s_ovf = c_ovf; s_data = {8'h00, c_data};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: true signed arithmetic on w-bit values, then clamp or wrap.
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic sub, input logic sat, input int w);
    int mask, half, sa, sb, r, res;
    logic o;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    sa = int'(a) & mask;
    sb = int'(b) & mask;
    if (sa >= half) sa = sa - (1 << w);
    if (sb >= half) sb = sb - (1 << w);
    r   = sub ? (sa - sb) : (sa + sb);
    o   = (r > half - 1) || (r < -half);
    res = (sat && o) ? ((r > 0) ? half - 1 : -half) : r;
    return {o, 16'(res & mask)};
  endfunction

  task automatic set_start(input int which, input logic v);
    st_m = (which == 0) ? v : 1'b0;
    st_w = (which == 1) ? v : 1'b0;
    st_c = (which == 2) ? v : 1'b0;
  endtask

  // Issue one operation and wait (bounded) for o_done. lat counts edges after
  // the accepting edge until o_done is seen.
  task automatic do_op(input int which, input logic [15:0] a, input logic [15:0] b,
                       input logic sub, output int lat);
    sel = which;
    @(negedge clk);
    a_in = a; b_in = b; sub_in = sub;
    set_start(which, 1'b1);
    @(negedge clk);
    set_start(which, 1'b0);
    lat = 0;
    while (!s_done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_check(input string name, input int which, input logic [15:0] a,
                           input logic [15:0] b, input logic sub, input logic sat,
                           input int w, input int exp_lat);
    int lat;
    logic [16:0] exp;
    exp = model(a, b, sub, sat, w);
    do_op(which, a, b, sub, lat);
    check({name, " latency"}, lat, exp_lat);
    check({name, " data"}, s_data, {16'h0, exp[15:0]});
    check({name, " ovf"}, s_ovf, exp[16]);
    check({name, " valid"}, s_valid, 1);
    check({name, " busy@done"}, s_busy, 0);
    @(negedge clk);
    check({name, " done pulse"}, s_done, 0);
    check({name, " valid hold"}, s_valid, 1);
  endtask

  // Protocol invariants on the main instance
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (m_busy && m_done) check("busy_done_excl", 1, 0);
      if (prev_done && m_done) check("done_two_cycles", 1, 0);
    end
    prev_done = m_done;
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] d;
    logic        ovf;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat, t, dones;
    logic [15:0] r1;
    logic [16:0] e1, e2;

    vecs[0] = '{16'h0180, 16'h0240, 1'b0, 16'h03C0, 1'b0};
    vecs[1] = '{16'h0100, 16'h0300, 1'b1, 16'hFE00, 1'b0};
    vecs[2] = '{16'h7F00, 16'h0200, 1'b0, 16'h7FFF, 1'b1};
    vecs[3] = '{16'h8000, 16'h0100, 1'b1, 16'h8000, 1'b1};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b1};
    vecs[5] = '{16'h0000, 16'h8000, 1'b1, 16'h7FFF, 1'b1};
    vecs[6] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0};

    rst = 1'b1; a_in = '0; b_in = '0; sub_in = 1'b0;
    st_m = 1'b0; st_w = 1'b0; st_c = 1'b0;
    repeat (3) @(negedge clk);
    check("rst busy", m_busy, 0);
    check("rst valid", m_valid, 0);
    check("rst done", m_done, 0);
    check("rst data", m_data, 0);
    check("rst ovf", m_ovf, 0);
    rst = 1'b0;

    // Directed vectors on the saturating instance
    for (int i = 0; i < 7; i++) begin
      do_op(0, vecs[i].a, vecs[i].b, vecs[i].sub, lat);
      check($sformatf("vec%0d latency", i), lat, 4);
      check($sformatf("vec%0d data", i), m_data, vecs[i].d);
      check($sformatf("vec%0d ovf", i), m_ovf, vecs[i].ovf);
      check($sformatf("vec%0d valid", i), m_valid, 1);
    end

    // Wrapping instance: positive overflow wraps but still flags
    do_op(1, 16'h7F00, 16'h0200, 1'b0, lat);
    check("wrap latency", lat, 4);
    check("wrap data", w_data, 16'h8100);
    check("wrap ovf", w_ovf, 1);

    // Single-chunk instance: 1-cycle latency
    run_check("c8 zero", 2, 16'h0000, 16'h0000, 1'b0, 1'b1, 8, 1);

    // Start during RUN is ignored
    sel = 0;
    e1 = model(16'h1234, 16'h0111, 1'b0, 1'b1, 16);
    @(negedge clk);
    a_in = 16'h1234; b_in = 16'h0111; sub_in = 1'b0; st_m = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      st_m = (i == 1);
      if (i == 1) begin a_in = 16'h0F0F; b_in = 16'h0F0F; end
      if (m_done) dones++;
    end
    st_m = 1'b0;
    check("busy start dones", dones, 1);
    check("busy start data", m_data, e1[15:0]);

    // Reset in the second RUN cycle aborts with no done
    @(negedge clk);
    a_in = 16'h7F00; b_in = 16'h0200; sub_in = 1'b0; st_m = 1'b1;
    @(negedge clk);
    st_m = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort busy", m_busy, 0);
    check("abort done", m_done, 0);
    check("abort valid", m_valid, 0);
    check("abort data", m_data, 0);
    check("abort ovf", m_ovf, 0);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (m_done) dones++;
    end
    check("abort no done", dones, 0);
    run_check("after abort", 0, 16'h0180, 16'h0240, 1'b0, 1'b1, 16, 4);

    // Back-to-back: second start issued in the DONE cycle
    e1 = model(16'h0500, 16'h0123, 1'b1, 1'b1, 16);
    e2 = model(16'h7000, 16'h2000, 1'b0, 1'b1, 16);
    do_op(0, 16'h0500, 16'h0123, 1'b1, lat);
    r1 = m_data;
    check("b2b first data", r1, e1[15:0]);
    a_in = 16'h7000; b_in = 16'h2000; sub_in = 1'b0; st_m = 1'b1;
    @(negedge clk);
    st_m = 1'b0;
    t = 1;
    check("b2b valid drop", m_valid, 0);
    check("b2b busy", m_busy, 1);
    check("b2b data hold", m_data, r1);
    while (!m_done && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("b2b spacing", t, 5);
    check("b2b second data", m_data, e2[15:0]);
    check("b2b second ovf", m_ovf, e2[16]);

    // Randomized operations against the reference model
    for (int i = 0; i < 30; i++)
      run_check($sformatf("rnd_sat%0d", i), 0, 16'($urandom), 16'($urandom),
                1'($urandom_range(0, 1)), 1'b1, 16, 4);
    for (int i = 0; i < 10; i++)
      run_check($sformatf("rnd_wrap%0d", i), 1, 16'($urandom), 16'($urandom),
                1'($urandom_range(0, 1)), 1'b0, 16, 4);
    for (int i = 0; i < 8; i++)
      run_check($sformatf("rnd_c8_%0d", i), 2, 16'($urandom_range(0, 255)),
                16'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1, 8, 1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fixed_point_addsub_mc.md
# fixed_point_addsub_mc

Parametrised, multi-cycle signed fixed-point adder/subtractor, successor to the single-width FixedPointAddSub. It processes operands CHUNK bits per clock, LSB first, so wide operands close timing on small FPGAs. It adds optional saturation and keeps the start/busy/done handshake. It sits in the DSP-filter datapath between coefficient/sample registers and the accumulator stages.

## Interface
- WIDTH, 16: operand/result width, two's complement; WIDTH ≥ 2.
- FRAC, 8: fractional bits (Q(WIDTH-FRAC).FRAC). Documentation only; does not change arithmetic.
- CHUNK, 4: bits processed per cycle; WIDTH % CHUNK == 0 is required (elaboration error otherwise).
- SATURATE, 1: 1 = clamp on overflow, 0 = wrap.

- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_start  in  1  request; sampled only when not busy.
- i_sub  in  1  0 = A+B, 1 = A−B; latched with start.
- i_operandA  in  WIDTH  signed operand A; latched with start.
- i_operandB  in  WIDTH  signed operand B; latched with start.
- o_busy  out  1  computation in progress.
- o_valid  out  1  o_data holds a completed result.
- o_done  out  1  one-cycle pulse on result completion.
- o_data  out  WIDTH  result.
- o_overflow  out  1  signed overflow of the last result, saturated or not.

## Operation
- NCHUNK = WIDTH/CHUNK. State machine has three states: IDLE, RUN, DONE.
- Start is accepted in IDLE or DONE when i_start=1.
  - Latch A, B' = i_sub ? ~B : B, carry = i_sub.
  - Clear the chunk counter and go to RUN.
  - Clear o_valid.
- RUN, each edge:
  - sum one CHUNK slice (counter index) of A, B' and carry into the result shift/slice register;
  - store carry-out;
  - increment the counter.
- On the edge that processes chunk NCHUNK−1:
  - overflow = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]);
  - if overflow && SATURATE: o_data = A[MSB] ? 100…0 : 011…1; otherwise o_data = raw sum;
  - set o_overflow, o_valid=1 and o_done=1, and go to DONE.
- DONE lasts one cycle. Next state is RUN if i_start (back-to-back), else IDLE.
- i_start in RUN is ignored; no queueing.
- o_data, o_overflow and o_valid hold until the next accepted start (o_valid drops) or reset. o_data and o_overflow hold even after o_valid drops, until overwritten.
- Reset has priority over everything.
  - All outputs go to 0, state goes to IDLE, and internal registers are cleared.
  - Reset mid-RUN aborts the operation; no o_done is produced.

## Timing
- Start is sampled at edge k. o_busy is 1 for cycles following edges k … k+NCHUNK−1 (NCHUNK cycles).
- o_done, o_valid and the new o_data/o_overflow appear after edge k+NCHUNK. Latency is NCHUNK cycles, 4 at the defaults.
- CHUNK = WIDTH gives 1-cycle latency, matching the previous block.
- Back-to-back throughput is one result per NCHUNK+1 cycles when a start is issued in the DONE cycle.
- o_done is never high for two consecutive cycles.
- o_busy and o_done are never high together.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package fixed_point_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the saturation constant functions max_pos(WIDTH) and min_neg(WIDTH);
  - the overflow-detect function, shared with other fixed-point blocks.
- Sub-module fixed_point_chunk_adder is a combinational CHUNK-bit adder with carry in/out, instantiated once.
- Top level holds the FSM, counter (clog2(NCHUNK) bits, min 1), operand/result registers and saturation mux.
- Formal harness follows the existing cover/assert flow:
  - f_past_valid guard;
  - cover for o_done with and without overflow;
  - assert o_busy and o_done mutually exclusive;
  - assert result equals a reference sum.

## Test plan
All cases use defaults (WIDTH=16, FRAC=8, CHUNK=4, SATURATE=1) unless stated.
- **Add, no overflow:** A=0x0180 (1.5), B=0x0240 (2.25), sub=0 → exactly 4 cycles after start, o_done pulse, o_data=0x03C0 (3.75), o_overflow=0, o_valid stays 1.
- **Subtract to negative:** A=0x0100, B=0x0300, sub=1 → o_data=0xFE00 (−2.0), o_overflow=0.
- **Positive overflow:** A=0x7F00, B=0x0200, sub=0 → o_overflow=1, o_data=0x7FFF. With SATURATE=0 → o_data=0x8100, o_overflow=1.
- **Negative overflow:** A=0x8000, B=0x0100, sub=1 → o_overflow=1, o_data=0x8000.
- **Start while busy, then reset:**
  - start, then i_start=1 again during RUN → second request ignored, single o_done;
  - new start, then i_rst at 2nd RUN cycle → no o_done, all outputs 0 next cycle;
  - fresh start afterwards completes normally.
- **Back-to-back:** start asserted in the DONE cycle → o_valid drops, o_busy rises next cycle, second o_done 5 cycles after the first.
- **CHUNK=WIDTH=8:** 0x00+0x00 start → o_done 1 cycle later, o_data=0x00.
